// File: rtl/csr_ddr3_pulse_arb.sv
// Round-robin arbiter that turns per-requester strobes into single pulses for a
// cross-clock pulse synchronizer, spacing successive pulses at least GAP cycles apart.
module csr_ddr3_pulse_arb #(
  parameter int N   = 4,
  parameter int GAP = 8,
  parameter int TW  = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          clr_ovf,
  output logic          pulse,
  output logic [TW-1:0] tag,
  output logic [N-1:0]  pend,
  output logic [N-1:0]  ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD
  } arbState_e;

  localparam logic [7:0] HOLD_LOAD = 8'(GAP - 2);

  arbState_e     state_q, state_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  ovf_q, ovf_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pulse_q;
  logic          en_q;

  logic [2*N-1:0] pendDbl;
  logic [N-1:0]   pendRot;
  logic [31:0]    grantOff;
  logic [31:0]    grantSum;
  logic [TW-1:0]  grantIdx;
  logic           grantAny;
  logic           startGrant;
  logic [N-1:0]   clrMask;

  // Rotate pend so the requester after the last-served tag sits at bit 0, then
  // take the lowest set bit; the offset maps back to an absolute index mod N.
  always_comb begin
    pendDbl  = {pend_q, pend_q} >> (32'(tag_q) + 32'd1);
    pendRot  = pendDbl[N-1:0];
    grantOff = 32'd0;
    for (int j = N - 1; j >= 0; j--) begin
      if (pendRot[j]) begin
        grantOff = 32'(j);
      end
    end
    grantSum = 32'(tag_q) + 32'd1 + grantOff;
    grantIdx = TW'(grantSum % N);
    grantAny = |pend_q;
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    startGrant = 1'b0;
    clrMask    = '0;

    case (state_q)
      IDLE: begin
        if (en_q && grantAny) begin
          startGrant = 1'b1;
        end
      end
      FIRE: begin
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          if (en_q && grantAny) begin
            startGrant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (startGrant) begin
      state_d = FIRE;
      tag_d   = grantIdx;
      clrMask = N'(1) << grantIdx;
    end

    // A strobe landing on the same edge as its own clear re-arms pend and is not an overflow.
    pend_d = (pend_q & ~clrMask) | req;
    ovf_d  = (ovf_q & ~{N{clr_ovf}}) | (req & pend_q & ~clrMask);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      tag_q   <= TW'(N - 1);
      pend_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= 8'd0;
      pulse_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      pulse_q <= (state_d == FIRE);
      en_q    <= en;
    end
  end

  assign pulse = pulse_q;
  assign tag   = tag_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_csr_ddr3_pulse_arb.sv
// Bench for csr_ddr3_pulse_arb: vector table, directed corner sequences and a
// randomized run against a cycle-arithmetic reference model.
module tb_csr_ddr3_pulse_arb;

  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TW  = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          en;
  logic [N-1:0]  req;
  logic          clr_ovf;
  logic          pulse;
  logic [TW-1:0] tag;
  logic [N-1:0]  pend;
  logic [N-1:0]  ovf;
  logic          busy;

  csr_ddr3_pulse_arb #(.N(N), .GAP(GAP), .TW(TW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .req       (req),
    .clr_ovf   (clr_ovf),
    .pulse     (pulse),
    .tag       (tag),
    .pend      (pend),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleNo     = 0;
  int pq[$];
  int tq[$];

  always @(posedge sys_clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic e, input logic c);
    @(posedge sys_clk);
    #1;
    req     = r;
    en      = e;
    clr_ovf = c;
  endtask

  task automatic resetDut();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    req       = '0;
    clr_ovf   = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  always @(negedge sys_clk) begin
    if (pulse === 1'b1) begin
      pq.push_back(cycleNo);
      tq.push_back(int'(tag));
    end
  end

  // Reference model: a pulse happens at a known cycle, busy spans GAP cycles from it,
  // and a new grant may start once GAP-1 cycles have elapsed since the last pulse.
  logic [N-1:0] mPend, mOvf, mClr;
  int           mTag, mLastPulse;
  bit           mHasPulse, mEnReg, mBusy, mPulseExp, mFound;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      mPend     = '0;
      mOvf      = '0;
      mTag      = N - 1;
      mHasPulse = 1'b0;
      mEnReg    = 1'b0;
    end
    mBusy     = mHasPulse && (cycleNo - mLastPulse < GAP);
    mPulseExp = mHasPulse && (cycleNo == mLastPulse);
    checkOutput("model.pulse", pulse, mPulseExp);
    checkOutput("model.tag", tag, mTag);
    checkOutput("model.pend", pend, mPend);
    checkOutput("model.ovf", ovf, mOvf);
    checkOutput("model.busy", busy, mBusy);
    if (sys_rst_n) begin
      mClr = '0;
      if (mEnReg && mPend != 0 && (!mHasPulse || cycleNo - mLastPulse >= GAP - 1)) begin
        mFound = 1'b0;
        for (int d = 1; d <= N; d++) begin
          if (!mFound && mPend[(mTag + d) % N]) begin
            mFound = 1'b1;
            mTag   = (mTag + d) % N;
          end
        end
        mClr[mTag] = 1'b1;
        mHasPulse  = 1'b1;
        mLastPulse = cycleNo + 1;
      end
      mOvf   = (clr_ovf ? '0 : mOvf) | (req & mPend & ~mClr);
      mPend  = (mPend & ~mClr) | req;
      mEnReg = en;
    end
  end

  typedef struct {
    logic [N-1:0]  vReq;
    logic          vEn;
    logic          vClr;
    logic          ePulse;
    logic [TW-1:0] eTag;
    logic [N-1:0]  ePend;
    logic [N-1:0]  eOvf;
    logic          eBusy;
  } vector_t;

  vector_t vec[13];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    int e;
    bit inReset;
    logic [N-1:0] r;

    vec[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0};
    vec[1]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0};
    vec[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0000, 1'b0};
    vec[3]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1};
    for (int i = 4; i <= 10; i++) vec[i] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};
    vec[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    vec[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};

    sys_rst_n = 1'b0;
    en        = 1'b0;
    req       = '0;
    clr_ovf   = 1'b0;
    repeat (2) @(negedge sys_clk);
    checkOutput("reset.pulse", pulse, 0);
    checkOutput("reset.tag", tag, N - 1);
    checkOutput("reset.pend", pend, 0);
    checkOutput("reset.ovf", ovf, 0);
    checkOutput("reset.busy", busy, 0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vec[i].vReq, vec[i].vEn, vec[i].vClr);
      @(negedge sys_clk);
      checkOutput($sformatf("vec%0d.pulse", i), pulse, vec[i].ePulse);
      checkOutput($sformatf("vec%0d.tag", i), tag, vec[i].eTag);
      checkOutput($sformatf("vec%0d.pend", i), pend, vec[i].ePend);
      checkOutput($sformatf("vec%0d.ovf", i), ovf, vec[i].eOvf);
      checkOutput($sformatf("vec%0d.busy", i), busy, vec[i].eBusy);
    end

    // All four requesters at once after reset: tags 0..3, GAP apart.
    resetDut();
    pq.delete();
    tq.delete();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    t = cycleNo;
    repeat (35) applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("all4.count", pq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pq.size()) begin
        checkOutput($sformatf("all4.when%0d", i), pq[i] - t, 2 + GAP * i);
        checkOutput($sformatf("all4.tag%0d", i), tq[i], i);
      end
    end
    checkOutput("all4.busy", busy, 0);

    // Overflow while disabled, including a set coincident with clr_ovf.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    @(negedge sys_clk);
    checkOutput("ovf.setVsClr", ovf, 4'b0100);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    @(negedge sys_clk);
    checkOutput("ovf.sticky", ovf, 4'b0100);
    checkOutput("ovf.pend", pend, 4'b0100);
    checkOutput("ovf.idle", busy, 0);
    pq.delete();
    tq.delete();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    e = cycleNo;
    repeat (15) applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("ovf.pulses", pq.size(), 1);
    if (pq.size() > 0) begin
      checkOutput("ovf.when", pq[0] - e, 2);
      checkOutput("ovf.tag", tq[0], 2);
    end
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("ovf.cleared", ovf, 0);

    // Re-request on the same edge that clears pend[1].
    pq.delete();
    tq.delete();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    t = cycleNo;
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("rearm.pulse", pulse, 1);
    checkOutput("rearm.tag", tag, 1);
    checkOutput("rearm.pend", pend, 4'b0010);
    checkOutput("rearm.ovf", ovf, 0);
    repeat (14) applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("rearm.count", pq.size(), 2);
    if (pq.size() > 1) begin
      checkOutput("rearm.first", pq[0] - t, 2);
      checkOutput("rearm.spacing", pq[1] - pq[0], GAP);
      checkOutput("rearm.tag2", tq[1], 1);
    end

    // Asynchronous reset in the middle of HOLD.
    repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0110, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("abort.pendBefore", pend, 4'b0110);
    checkOutput("abort.busyBefore", busy, 1);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("abort.pulse", pulse, 0);
    checkOutput("abort.pend", pend, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.tag", tag, N - 1);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    pq.delete();
    tq.delete();
    applyStimulus(4'b1010, 1'b1, 1'b0);
    t = cycleNo;
    repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("abort.count", pq.size(), 1);
    if (pq.size() > 0) begin
      checkOutput("abort.when", pq[0] - t, 2);
      checkOutput("abort.firstTag", tq[0], 1);
    end

    // Enable dropped during HOLD: sequence completes, pend held until re-enabled.
    repeat (16) applyStimulus(4'b0000, 1'b1, 1'b0);
    pq.delete();
    tq.delete();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0);
    @(negedge sys_clk);
    checkOutput("endrop.busy", busy, 0);
    checkOutput("endrop.pend", pend, 4'b0001);
    repeat (10) applyStimulus(4'b0000, 1'b0, 1'b0);
    @(negedge sys_clk);
    checkOutput("endrop.held", pq.size(), 1);
    pq.delete();
    tq.delete();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    e = cycleNo;
    repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);
    checkOutput("endrop.count", pq.size(), 1);
    if (pq.size() > 0) begin
      checkOutput("endrop.when", pq[0] - e, 2);
      checkOutput("endrop.tag", tq[0], 0);
    end

    // Randomized traffic; the model above checks every cycle.
    inReset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 5) == 0);
      applyStimulus(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
      if (inReset) begin
        sys_rst_n = 1'b1;
        inReset   = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        sys_rst_n = 1'b0;
        inReset   = 1'b1;
      end
    end
    sys_rst_n = 1'b1;
    repeat (GAP * (N + 2)) applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
